// File: rtl/csoc_cmd_parser_if.sv
// Byte-stream handshake between the board UART and the CSoC command parser.
// The master modport is the UART side and the slave modport is the parser side.
interface csoc_cmd_parser_if;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;

  modport master (output rx_data, new_rx_data, tx_busy, input tx_data, new_tx_data);
  modport slave  (input rx_data, new_rx_data, tx_busy, output tx_data, new_tx_data);
endinterface

// File: rtl/csoc_cmd_parser.sv
// Host-driven CSoC test sequencer: decodes UART opcode/argument frames into pin control,
// clock bursts and data bus transfers, and answers every command with a byte reply.
module csoc_cmd_parser #(
  parameter int CSOC_DATA_W = 8,
  parameter int CLK_DIV     = 2,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic                   clk,
  input  logic                   rstn,
  csoc_cmd_parser_if.slave       uart,
  output logic                   csoc_clk,
  output logic                   csoc_rstn,
  output logic                   csoc_test_se,
  output logic                   csoc_test_tm,
  input  logic                   csoc_uart_write,
  output logic                   csoc_uart_read,
  input  logic [CSOC_DATA_W-1:0] csoc_data_i,
  output logic [CSOC_DATA_W-1:0] csoc_data_o,
  output logic [7:0]             leds,
  output logic                   busy
);

  localparam int NB = CSOC_DATA_W / 8;
  localparam int AW = (CSOC_DATA_W > 16) ? CSOC_DATA_W : 16;
  localparam int TW = 8 * (NB + 1);
  localparam logic [15:0] HC_INIT = 16'(CLK_DIV - 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [7:0] OP_CTRL = 8'h01, OP_CLOCK = 8'h02, OP_WRITE = 8'h03;
  localparam logic [7:0] OP_READ = 8'h04, OP_UREAD = 8'h05, OP_STATUS = 8'h06;
  localparam logic [7:0] REPLY_ERR = 8'hEE;

  typedef enum logic [2:0] {S_IDLE, S_ARG, S_EXEC, S_TX_LOAD, S_TX_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             op_q, op_d;
  logic [2:0]             argn_q, argn_d;
  logic [AW-9:0]          arg_q, arg_d;
  logic [31:0]            to_q, to_d;
  logic [15:0]            hc_q, hc_d;
  logic [15:0]            per_q, per_d;
  logic                   cclk_q, cclk_d;
  logic                   rst_q, rst_d;
  logic                   se_q, se_d;
  logic                   tm_q, tm_d;
  logic [CSOC_DATA_W-1:0] do_q, do_d;
  logic                   uread_q, uread_d;
  logic [TW-1:0]          txbuf_q, txbuf_d;
  logic [2:0]             txn_q, txn_d;
  logic                   err_q, err_d;
  logic                   ovr_q, ovr_d;
  logic                   uws_q, uws_d;
  logic                   uwp_q;
  logic [7:0]             leds_q;

  logic [AW-1:0] arg_full;
  logic          rx_drop;
  logic          uw_rise;

  assign arg_full = {arg_q, uart.rx_data};
  assign rx_drop  = uart.new_rx_data && (state_q != S_IDLE) && (state_q != S_ARG);
  assign uw_rise  = csoc_uart_write && !uwp_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    argn_d  = argn_q;
    arg_d   = arg_q;
    to_d    = to_q;
    hc_d    = hc_q;
    per_d   = per_q;
    cclk_d  = cclk_q;
    rst_d   = rst_q;
    se_d    = se_q;
    tm_d    = tm_q;
    do_d    = do_q;
    uread_d = 1'b0;
    txbuf_d = txbuf_q;
    txn_d   = txn_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    uws_d   = uws_q;

    case (state_q)
      S_IDLE: begin
        if (uart.new_rx_data) begin
          op_d  = uart.rx_data;
          arg_d = '0;
          to_d  = '0;
          case (uart.rx_data)
            OP_CTRL:  begin argn_d = 3'd1;    state_d = S_ARG; end
            OP_CLOCK: begin argn_d = 3'd2;    state_d = S_ARG; end
            OP_WRITE: begin argn_d = 3'(NB);  state_d = S_ARG; end
            OP_READ, OP_UREAD, OP_STATUS: state_d = S_EXEC;
            default: begin
              err_d   = 1'b1;
              txbuf_d = {REPLY_ERR, {(TW-8){1'b0}}};
              txn_d   = 3'd1;
              state_d = S_TX_LOAD;
            end
          endcase
        end
      end
      S_ARG: begin
        if (uart.new_rx_data) begin
          arg_d  = arg_full[AW-9:0];
          to_d   = '0;
          argn_d = argn_q - 3'd1;
          if (argn_q == 3'd1) begin
            txbuf_d = {op_q, {(TW-8){1'b0}}};
            txn_d   = 3'd1;
            state_d = S_TX_LOAD;
            case (op_q)
              OP_CTRL: begin
                rst_d = uart.rx_data[0];
                se_d  = uart.rx_data[1];
                tm_d  = uart.rx_data[2];
              end
              OP_CLOCK: begin
                // N=0 falls through to an immediate reply with no edges
                if (arg_full[15:0] != 16'd0) begin
                  per_d   = arg_full[15:0];
                  cclk_d  = 1'b1;
                  hc_d    = HC_INIT;
                  state_d = S_EXEC;
                end
              end
              OP_WRITE: do_d = arg_full[CSOC_DATA_W-1:0];
              default: ;
            endcase
          end
        end else if (to_q >= TO_LAST) begin
          err_d   = 1'b1;
          txbuf_d = {REPLY_ERR, {(TW-8){1'b0}}};
          txn_d   = 3'd1;
          state_d = S_TX_LOAD;
        end else begin
          to_d = to_q + 32'd1;
        end
      end
      S_EXEC: begin
        txbuf_d = {op_q, {(TW-8){1'b0}}};
        txn_d   = 3'd1;
        state_d = S_TX_LOAD;
        case (op_q)
          OP_READ: begin
            txbuf_d = {op_q, csoc_data_i};
            txn_d   = 3'(NB + 1);
          end
          OP_UREAD: uread_d = 1'b1;
          OP_STATUS: begin
            txbuf_d = {4'b0, csoc_uart_write, uws_q, ovr_q, err_q, {(TW-8){1'b0}}};
            err_d   = 1'b0;
            ovr_d   = 1'b0;
            uws_d   = 1'b0;
          end
          OP_CLOCK: begin
            state_d = S_EXEC;
            if (hc_q != 16'd0) begin
              hc_d = hc_q - 16'd1;
            end else if (cclk_q) begin
              cclk_d = 1'b0;
              hc_d   = HC_INIT;
            end else if (per_q == 16'd1) begin
              per_d   = 16'd0;
              state_d = S_TX_LOAD;
            end else begin
              per_d  = per_q - 16'd1;
              cclk_d = 1'b1;
              hc_d   = HC_INIT;
            end
          end
          default: ;
        endcase
      end
      S_TX_LOAD: begin
        if (!uart.tx_busy) begin
          txbuf_d = txbuf_q << 8;
          txn_d   = txn_q - 3'd1;
          state_d = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (!uart.tx_busy) state_d = (txn_q != 3'd0) ? S_TX_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Set events come after the STATUS clear so a coincident event is not lost
    if (rx_drop) ovr_d = 1'b1;
    if (uw_rise) uws_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      argn_q  <= '0;
      arg_q   <= '0;
      to_q    <= '0;
      hc_q    <= '0;
      per_q   <= '0;
      cclk_q  <= 1'b0;
      rst_q   <= 1'b0;
      se_q    <= 1'b0;
      tm_q    <= 1'b0;
      do_q    <= '0;
      uread_q <= 1'b0;
      txbuf_q <= '0;
      txn_q   <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      uws_q   <= 1'b0;
      uwp_q   <= 1'b0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      argn_q  <= argn_d;
      arg_q   <= arg_d;
      to_q    <= to_d;
      hc_q    <= hc_d;
      per_q   <= per_d;
      cclk_q  <= cclk_d;
      rst_q   <= rst_d;
      se_q    <= se_d;
      tm_q    <= tm_d;
      do_q    <= do_d;
      uread_q <= uread_d;
      txbuf_q <= txbuf_d;
      txn_q   <= txn_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      uws_q   <= uws_d;
      uwp_q   <= csoc_uart_write;
      leds_q  <= {cclk_q, rst_q, se_q, tm_q, uws_q, busy, ovr_q, err_q};
    end
  end

  assign uart.tx_data     = txbuf_q[TW-1 -: 8];
  assign uart.new_tx_data = (state_q == S_TX_LOAD) && !uart.tx_busy;
  assign busy             = (state_q != S_IDLE);
  assign csoc_clk         = cclk_q;
  assign csoc_rstn        = rst_q;
  assign csoc_test_se     = se_q;
  assign csoc_test_tm     = tm_q;
  assign csoc_uart_read   = uread_q;
  assign csoc_data_o      = do_q;
  assign leds             = leds_q;

endmodule

// File: tb/tb_csoc_cmd_parser.sv
// Directed bench for csoc_cmd_parser with a 16-bit data bus, CLK_DIV=2 and a short timeout.
module tb_csoc_cmd_parser;
  localparam int DW = 16;
  localparam int CD = 2;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rstn;
  logic          csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;
  logic          csoc_uart_write = 1'b0;
  logic          csoc_uart_read;
  logic [DW-1:0] csoc_data_i = '0;
  logic [DW-1:0] csoc_data_o;
  logic [7:0]    leds;
  logic          busy;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] txq[$];
  logic       pend = 1'b0;
  int         bcnt = 0;

  always #5 clk = ~clk;

  csoc_cmd_parser_if uart ();

  csoc_cmd_parser #(.CSOC_DATA_W(DW), .CLK_DIV(CD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rstn(rstn), .uart(uart),
    .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn),
    .csoc_test_se(csoc_test_se), .csoc_test_tm(csoc_test_tm),
    .csoc_uart_write(csoc_uart_write), .csoc_uart_read(csoc_uart_read),
    .csoc_data_i(csoc_data_i), .csoc_data_o(csoc_data_o),
    .leds(leds), .busy(busy)
  );

  // UART transmitter model: busy for three cycles starting the cycle after a send
  assign uart.tx_busy = (bcnt != 0);
  always @(negedge clk) begin
    pend <= uart.new_tx_data;
    if (pend) bcnt <= 3;
    else if (bcnt != 0) bcnt <= bcnt - 1;
    if (uart.new_tx_data) txq.push_back(uart.tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart.rx_data     = b;
    uart.new_rx_data = 1'b1;
    @(negedge clk);
    uart.new_rx_data = 1'b0;
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    int w = 0;
    while (txq.size() == 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (txq.size() == 0) chk({tag, "_timeout"}, 32'h1FF, {24'h0, exp});
    else chk(tag, {24'h0, txq.pop_front()}, {24'h0, exp});
  endtask

  task automatic idle_wait();
    int w = 0;
    while (busy && w < 3000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic clock_burst(input string tag, input logic [15:0] n);
    int rises = 0, highs = 0, cyc = 0;
    logic prev = 1'b0;
    send_byte(8'h02);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    while (!uart.new_tx_data && cyc < 1000) begin
      if (csoc_clk && !prev) rises++;
      if (csoc_clk) highs++;
      prev = csoc_clk;
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_rises"}, rises, {16'h0, n});
    chk({tag, "_high_cycles"}, highs, n * CD);
    chk({tag, "_burst_cycles"}, cyc, n * 2 * CD);
    expect_tx({tag, "_reply"}, 8'h02);
    idle_wait();
  endtask

  initial begin
    int ur;
    uart.rx_data     = 8'h00;
    uart.new_rx_data = 1'b0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_csoc_clk", csoc_clk, 0);
    chk("rst_csoc_rstn", csoc_rstn, 0);
    chk("rst_se_tm", {csoc_test_se, csoc_test_tm}, 0);
    chk("rst_leds", leds, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_o", csoc_data_o, 0);
    chk("rst_new_tx", uart.new_tx_data, 0);
    rstn = 1'b1;
    @(negedge clk);

    send_byte(8'h01);
    send_byte(8'h05);
    chk("ctrl_rstn", csoc_rstn, 1);
    chk("ctrl_se", csoc_test_se, 0);
    chk("ctrl_tm", csoc_test_tm, 1);
    expect_tx("ctrl_reply", 8'h01);
    idle_wait();
    chk("ctrl_led6", leds[6], 1);
    chk("ctrl_led4", leds[4], 1);
    chk("ctrl_leds", leds, 8'h50);

    clock_burst("clk3", 16'd3);
    clock_burst("clk0", 16'd0);

    send_byte(8'h03);
    send_byte(8'hAB);
    chk("write_partial", csoc_data_o, 16'h0000);
    send_byte(8'hCD);
    chk("write_data", csoc_data_o, 16'hABCD);
    expect_tx("write_reply", 8'h03);
    idle_wait();

    csoc_data_i = 16'h1234;
    send_byte(8'h04);
    expect_tx("read_op", 8'h04);
    expect_tx("read_msb", 8'h12);
    expect_tx("read_lsb", 8'h34);
    idle_wait();

    send_byte(8'h7F);
    expect_tx("badop_reply", 8'hEE);
    idle_wait();
    chk("badop_led0", leds[0], 1);
    chk("badop_leds", leds, 8'h51);
    send_byte(8'h06);
    expect_tx("status_err", 8'h01);
    idle_wait();
    chk("status_clr_led0", leds[0], 0);

    send_byte(8'h04);
    send_byte(8'h55);
    expect_tx("ovr_read_op", 8'h04);
    expect_tx("ovr_read_msb", 8'h12);
    expect_tx("ovr_read_lsb", 8'h34);
    idle_wait();
    chk("ovr_led1", leds[1], 1);
    send_byte(8'h06);
    expect_tx("status_ovr", 8'h02);
    idle_wait();
    send_byte(8'h06);
    expect_tx("status_clean", 8'h00);
    idle_wait();

    send_byte(8'h05);
    ur = 0;
    for (int i = 0; i < 10; i++) begin
      if (csoc_uart_read) ur++;
      @(negedge clk);
    end
    chk("uread_pulses", ur, 1);
    expect_tx("uread_reply", 8'h05);
    idle_wait();

    csoc_uart_write = 1'b1;
    repeat (3) @(negedge clk);
    chk("uw_led3", leds[3], 1);
    send_byte(8'h06);
    expect_tx("status_uw", 8'h0C);
    idle_wait();
    csoc_uart_write = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h06);
    expect_tx("status_uw_clr", 8'h00);
    idle_wait();

    send_byte(8'h03);
    expect_tx("timeout_reply", 8'hEE);
    idle_wait();
    chk("timeout_data_kept", csoc_data_o, 16'hABCD);
    send_byte(8'h06);
    expect_tx("timeout_status", 8'h01);
    idle_wait();

    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h10);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_csoc_clk", csoc_clk, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (50) @(negedge clk);
    chk("midrst_no_reply", txq.size(), 0);
    chk("midrst_leds", leds, 0);
    chk("midrst_csoc_clk_idle", csoc_clk, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/csoc_cmd_parser.md
Name: csoc_cmd_parser

Overview:
Byte-level command interpreter between the board UART (rx/tx byte handshakes) and the CSoC test interface. It decodes opcode+argument frames to drive CSoC reset/scan/test-mode pins, burst a divided csoc_clk for N periods, and write or read a CSOC_DATA_W-bit data bus. Every command gets a byte response; status goes to the board leds. It replaces the free-running toggle logic with a deterministic, host-controlled sequencer.

Parameters:
CSOC_DATA_W, 8, CSoC data bus width; multiple of 8; NB = CSOC_DATA_W/8 bytes per transfer (1..4)
CLK_DIV, 2, clk cycles per csoc_clk half-period (>=1)
TIMEOUT_CYC, 50000000, max clk cycles between argument bytes before frame abort (1 s at 50 MHz)

Ports:
clk  in  1  system clock (50 MHz)
rstn  in  1  asynchronous active-low reset
rx_data  in  8  received byte
new_rx_data  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to transmit
new_tx_data  out  1  one-cycle strobe, tx_data valid
tx_busy  in  1  transmitter busy; high from the cycle after new_tx_data until done
csoc_clk  out  1  CSoC clock
csoc_rstn  out  1  CSoC reset
csoc_test_se  out  1  scan enable
csoc_test_tm  out  1  test mode
csoc_uart_write  in  1  CSoC has data for host (level)
csoc_uart_read  out  1  one-cycle read-acknowledge to CSoC
csoc_data_i  in  CSOC_DATA_W  CSoC output data
csoc_data_o  out  CSOC_DATA_W  data driven to CSoC
leds  out  8  status display
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rstn low): all outputs 0, leds 0, sticky flags 0, FSM IDLE, counters 0. Reset mid-command aborts with no reply; csoc_clk forced low.
- FSM: IDLE -> ARG (collect args) -> EXEC -> TX_LOAD <-> TX_WAIT -> IDLE.
- Opcodes (first byte in IDLE); multi-byte args MSB first; reply = opcode echo unless stated:
  0x01 CTRL, 1 arg b: csoc_rstn=b[0], se=b[1], tm=b[2], updated the cycle after the arg strobe.
  0x02 CLOCK, 2 args N[15:0]: N full periods, each CLK_DIV cycles high then CLK_DIV low, starting the cycle after the last arg; reply queued after the final low half completes. N=0: no edges, immediate reply.
  0x03 WRITE, NB args: csoc_data_o updated atomically after the last byte (unchanged until then).
  0x04 READ, 0 args: csoc_data_i sampled the cycle after the opcode strobe; reply = 0x04 then NB data bytes MSB first.
  0x05 UREAD, 0 args: csoc_uart_read high exactly 1 cycle; reply 0x05.
  0x06 STATUS, 0 args: reply {4'b0, csoc_uart_write, uw_seen, overrun, err}; clears overrun and err (set events in the same cycle win).
  Other: reply 0xEE, err=1.
- Timeout: in ARG, counter resets on each strobe; reaching TIMEOUT_CYC -> discard frame, reply 0xEE, err=1.
- RX while not in IDLE/ARG: byte dropped, overrun=1.
- TX: new_tx_data pulses only in TX_LOAD with tx_busy low; TX_WAIT lasts >=1 cycle and exits when tx_busy low; next byte or IDLE.
- uw_seen: sticky, set on csoc_uart_write rising edge; cleared by STATUS and reset only.
- leds (registered, 1-cycle lag): [7] csoc_clk, [6] csoc_rstn, [5] se, [4] tm, [3] uw_seen, [2] busy, [1] overrun, [0] err.

Test Plan:
- Reset, then 0x01 0x05 -> csoc_rstn=1, se=0, tm=1 next cycle; tx 0x01; leds[6]=1, leds[4]=1.
- 0x02 0x00 0x03, CLK_DIV=2 -> exactly 3 csoc_clk periods of 4 clk each, then tx 0x02; 0x02 0x00 0x00 -> no edges, tx 0x02.
- CSOC_DATA_W=16: 0x03 0xAB 0xCD -> csoc_data_o=0xABCD after last byte only; csoc_data_i=0x1234, 0x04 -> tx 0x04,0x12,0x34.
- 0x7F -> tx 0xEE, leds[0]=1; 0x06 -> tx 0x01, err cleared; extra byte during tx -> overrun=1.
- 0x03 followed by silence for TIMEOUT_CYC (overridden to 100) -> tx 0xEE, csoc_data_o unchanged; rstn low mid-CLOCK burst -> csoc_clk=0, no reply.
